decode_stage: RTL and testbench

Instruction decode stage directly upstream of the execute ALU. Accepts one RV32I instruction per cycle from fetch, reads operands from an internal 32×32 register file, and converts the instruction to the 4-bit ALU opcode plus two 32-bit operands. Presents these in a registered valid/ready output slot. A per-register scoreboard stalls issue on read-after-write hazards until writeback returns.

---
 rtl/riscv_pkg.sv | 72 +++++++
 rtl/decode_stage_regfile.sv | 44 ++++
 rtl/decode_stage.sv | 117 +++++++++++
 tb/tb_decode_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: ALU opcodes, major opcodes, funct fields,
// and a helper that classifies an instruction word into format + ALU op.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_LTU = 4'd5;
    localparam logic [3:0] ALU_GT  = 4'd6;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        FMT_ILLEGAL = 2'd0,
        FMT_REG     = 2'd1,
        FMT_IMM     = 2'd2
    } fmt_t;

    typedef struct packed {
        fmt_t       fmt;
        logic [3:0] alu_op;
    } dec_t;

    // Unsupported encodings come back as FMT_ILLEGAL with ALU_ADD (opcode 0).
    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        d.fmt    = FMT_ILLEGAL;
        d.alu_op = ALU_ADD;
        case (instr[6:0])
            OP_REG: begin
                d.fmt = FMT_REG;
                case ({instr[31:25], instr[14:12]})
                    {F7_BASE, F3_ADD}:  d.alu_op = ALU_ADD;
                    {F7_SUB,  F3_ADD}:  d.alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}:  d.alu_op = ALU_AND;
                    {F7_BASE, F3_OR}:   d.alu_op = ALU_OR;
                    {F7_BASE, F3_XOR}:  d.alu_op = ALU_XOR;
                    {F7_BASE, F3_SLTU}: d.alu_op = ALU_LTU;
                    default:            d.fmt    = FMT_ILLEGAL;
                endcase
            end
            OP_IMM: begin
                d.fmt = FMT_IMM;
                case (instr[14:12])
                    F3_ADD:  d.alu_op = ALU_ADD;
                    F3_AND:  d.alu_op = ALU_AND;
                    F3_OR:   d.alu_op = ALU_OR;
                    F3_XOR:  d.alu_op = ALU_XOR;
                    F3_SLTU: d.alu_op = ALU_LTU;
                    default: d.fmt    = FMT_ILLEGAL;
                endcase
            end
            default: d.fmt = FMT_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 2R1W register file with x0 hardwired to zero. With DECODE_BYPASS_EN defined,
// a same-cycle writeback is forwarded to a matching read port.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            rs1_hit;
    logic            rs2_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rs1_hit = wb_en && (wb_rd == rs1_addr);
    assign rs2_hit = wb_en && (wb_rd == rs2_addr);
`else
    assign rs1_hit = 1'b0;
    assign rs2_hit = 1'b0;
`endif

    // x0 check comes first so a forwarded write to x0 can never leak through.
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : (rs1_hit ? wb_data : regs[rs1_addr]);
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : (rs2_hit ? wb_data : regs[rs2_addr]);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: ALU op + operands into a registered valid/ready slot,
// with a pending-bit scoreboard for RAW hazards. DECODE_BYPASS_EN enables writeback forwarding.
module decode_stage #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_opcode,
    output logic [XLEN-1:0] ex_num1,
    output logic [XLEN-1:0] ex_num2,
    output logic [4:0]      ex_rd,
    output logic            ex_wb_en,
    output logic            ex_illegal
);
    import riscv_pkg::*;

    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [11:0]     imm;
    dec_t            dec;
    logic            legal;
    logic            is_reg;
    logic            issue_wb;
    logic            stall;
    logic            accept;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] num2_sel;

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] busy;

    assign rd  = in_instr[11:7];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign imm = in_instr[31:20];

    assign dec      = decode_instr(in_instr);
    assign legal    = (dec.fmt != FMT_ILLEGAL);
    assign is_reg   = (dec.fmt == FMT_REG);
    assign issue_wb = legal && (rd != 5'd0);
    assign num2_sel = is_reg ? rs2_data : {{(XLEN-12){imm[11]}}, imm};

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    // Per-register scoreboard: a new issue to rd outranks a same-cycle clear.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_sb
            assign wb_hit[gi] = wb_en && (wb_rd == 5'(gi)) && (gi != 0);
            assign pending_next[gi] = (accept && issue_wb && (rd == 5'(gi)))
                                    | (pending_reg[gi] & ~wb_hit[gi]);
`ifdef DECODE_BYPASS_EN
            assign busy[gi] = pending_reg[gi] & ~wb_hit[gi];
`else
            assign busy[gi] = pending_reg[gi];
`endif
        end
    endgenerate

    // Illegal encodings have no real sources, so they never wait on the scoreboard.
    assign stall    = legal && (busy[rs1] || (is_reg && busy[rs2]));
    assign in_ready = (!ex_valid || ex_ready) && !stall;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_num1     <= '0;
            ex_num2     <= '0;
            ex_rd       <= '0;
            ex_wb_en    <= 1'b0;
            ex_illegal  <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (accept) begin
                ex_valid   <= 1'b1;
                ex_opcode  <= dec.alu_op;
                ex_num1    <= legal ? rs1_data : '0;
                ex_num2    <= legal ? num2_sel : '0;
                ex_rd      <= legal ? rd : 5'd0;
                ex_wb_en   <= issue_wb;
                ex_illegal <= !legal;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus hazard, backpressure,
// x0 and reset sequences, with an expected-issue queue popped on each output handshake.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_opcode;
    logic [31:0] ex_num1;
    logic [31:0] ex_num2;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        ex_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_opcode  (ex_opcode),
        .ex_num1    (ex_num1),
        .ex_num2    (ex_num2),
        .ex_rd      (ex_rd),
        .ex_wb_en   (ex_wb_en),
        .ex_illegal (ex_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[15];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Output monitor: every consumed slot must match the oldest expected issue.
    always @(negedge clk) begin
        vec_t e;
        if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got issue op=%0d rd=%0d expected none", ex_opcode, ex_rd);
            end else begin
                e = exp_q.pop_front();
                $display("issue instr=%08h op=%0d num1=%08h num2=%08h rd=%0d wb=%0d ill=%0d",
                         e.instr, ex_opcode, ex_num1, ex_num2, ex_rd, ex_wb_en, ex_illegal);
                chk("out_opcode", 32'(ex_opcode), 32'(e.op));
                chk("out_num1", ex_num1, e.n1);
                chk("out_num2", ex_num2, e.n2);
                if (!e.ill) chk("out_rd", 32'(ex_rd), 32'(e.rd));
                chk("out_wb_en", 32'(ex_wb_en), 32'(e.wb));
                chk("out_illegal", 32'(ex_illegal), 32'(e.ill));
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic send(input vec_t v, input bit expect_now);
        int n;
        in_instr = v.instr;
        in_valid = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        if (expect_now) chk("in_ready_now", 32'(in_ready), 32'd1);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for instr %08h expected accept", v.instr);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t a, b, v;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_opcode", 32'(ex_opcode), 32'd0);
        chk("rst_ex_num1", ex_num1, 32'd0);
        chk("rst_ex_num2", ex_num2, 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_ex_wb_en", 32'(ex_wb_en), 32'd0);
        chk("rst_ex_illegal", 32'(ex_illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        wb_write(5'd3, 32'h1234_5678);
        wb_write(5'd5, 32'd100);
        wb_write(5'd6, 32'd30);
        wb_write(5'd7, 32'h8000_0000);

        tbl[0]  = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1), 4'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0};
        tbl[1]  = '{enc_i(12'hFFF, 5'd3, 3'b100, 5'd2), 4'd4, 32'h1234_5678, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0};
        tbl[2]  = '{enc_r(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd4), 4'd1, 32'd100, 32'd30, 5'd4, 1'b1, 1'b0};
        tbl[3]  = '{enc_r(7'b0000000, 5'd6, 5'd5, 3'b000, 5'd8), 4'd0, 32'd100, 32'd30, 5'd8, 1'b1, 1'b0};
        tbl[4]  = '{enc_r(7'b0000000, 5'd3, 5'd7, 3'b111, 5'd9), 4'd2, 32'h8000_0000, 32'h1234_5678, 5'd9, 1'b1, 1'b0};
        tbl[5]  = '{enc_r(7'b0000000, 5'd5, 5'd3, 3'b110, 5'd10), 4'd3, 32'h1234_5678, 32'd100, 5'd10, 1'b1, 1'b0};
        tbl[6]  = '{enc_r(7'b0000000, 5'd6, 5'd7, 3'b100, 5'd11), 4'd4, 32'h8000_0000, 32'd30, 5'd11, 1'b1, 1'b0};
        tbl[7]  = '{enc_r(7'b0000000, 5'd5, 5'd6, 3'b011, 5'd12), 4'd5, 32'd30, 32'd100, 5'd12, 1'b1, 1'b0};
        tbl[8]  = '{enc_i(12'h0F0, 5'd3, 3'b111, 5'd13), 4'd2, 32'h1234_5678, 32'h0000_00F0, 5'd13, 1'b1, 1'b0};
        tbl[9]  = '{enc_i(12'h800, 5'd5, 3'b110, 5'd14), 4'd3, 32'd100, 32'hFFFF_F800, 5'd14, 1'b1, 1'b0};
        tbl[10] = '{enc_i(12'h7FF, 5'd6, 3'b011, 5'd15), 4'd5, 32'd30, 32'h0000_07FF, 5'd15, 1'b1, 1'b0};
        tbl[11] = '{{12'd0, 5'd3, 3'b010, 5'd16, 7'b0000011}, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
        tbl[12] = '{enc_i(12'd7, 5'd0, 3'b000, 5'd0), 4'd0, 32'd0, 32'd7, 5'd0, 1'b0, 1'b0};
        tbl[13] = '{enc_r(7'b0000001, 5'd6, 5'd5, 3'b000, 5'd27), 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
        tbl[14] = '{enc_r(7'b0000000, 5'd6, 5'd5, 3'b001, 5'd28), 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};

        for (int i = 0; i < 15; i++) begin
            send(tbl[i], 1'b1);
        end

        // x16 (illegal LW target) and x0 must not be pending.
        send('{enc_i(12'd1, 5'd16, 3'b000, 5'd17), 4'd0, 32'd0, 32'd1, 5'd17, 1'b1, 1'b0}, 1'b1);
        send('{enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd19), 4'd0, 32'd0, 32'd0, 5'd19, 1'b1, 1'b0}, 1'b1);

        // RAW: ADD x2,x1,x1 waits on the ADDI x1 from the table.
        in_instr = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
        in_valid = 1'b1;
        exp_q.push_back('{in_instr, 4'd0, 32'd5, 32'd5, 5'd2, 1'b1, 1'b0});
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        @(negedge clk);
`ifdef DECODE_BYPASS_EN
        chk("raw_wb_cycle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        wb_en = 1'b0;
`else
        chk("raw_wb_cycle_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wb_en = 1'b0;
        @(negedge clk);
        chk("raw_next_cycle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
`endif
        in_valid = 1'b0;

        send('{enc_i(12'd2, 5'd1, 3'b000, 5'd26), 4'd0, 32'd5, 32'd2, 5'd26, 1'b1, 1'b0}, 1'b1);

        wb_write(5'd0, 32'd9);
        send('{enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd22), 4'd0, 32'd0, 32'd0, 5'd22, 1'b1, 1'b0}, 1'b1);

        // Backpressure: slot must hold A while B waits.
        repeat (2) begin
            @(posedge clk); #1;
        end
        a = '{enc_i(12'd1, 5'd5, 3'b000, 5'd20), 4'd0, 32'd100, 32'd1, 5'd20, 1'b1, 1'b0};
        b = '{enc_i(12'd3, 5'd6, 3'b110, 5'd21), 4'd3, 32'd30, 32'd3, 5'd21, 1'b1, 1'b0};
        ex_ready = 1'b0;
        in_instr = a.instr; in_valid = 1'b1; exp_q.push_back(a);
        @(negedge clk);
        chk("bp_accept_a", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_instr = b.instr; exp_q.push_back(b);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_ex_valid", 32'(ex_valid), 32'd1);
            chk("bp_hold_opcode", 32'(ex_opcode), 32'(a.op));
            chk("bp_hold_num1", ex_num1, a.n1);
            chk("bp_hold_num2", ex_num2, a.n2);
            chk("bp_hold_rd", 32'(ex_rd), 32'(a.rd));
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Reset mid-operation with a held slot and an in-flight writeback.
        ex_ready = 1'b0;
        v = '{enc_i(12'd1, 5'd0, 3'b000, 5'd23), 4'd0, 32'd0, 32'd1, 5'd23, 1'b1, 1'b0};
        in_instr = v.instr; in_valid = 1'b1; exp_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_valid", 32'(ex_valid), 32'd1);
        #2 rst = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("rst_mid_async_valid", 32'(ex_valid), 32'd0);
        chk("rst_mid_async_rd", 32'(ex_rd), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        wb_en = 1'b0;
        rst = 1'b0;
        ex_ready = 1'b1;
        send('{enc_r(7'b0000000, 5'd5, 5'd3, 3'b000, 5'd24), 4'd0, 32'd0, 32'd0, 5'd24, 1'b1, 1'b0}, 1'b1);
        send('{enc_i(12'd4, 5'd23, 3'b000, 5'd25), 4'd0, 32'd0, 32'd4, 5'd25, 1'b1, 1'b0}, 1'b1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
